// File: rtl/sonata_pkg.sv
// Shared Sonata definitions: pin counts, filter depth and pin vector type.
// Also holds a helper sizing the per-bit saturating filter counter.
package sonata_pkg;

  localparam int IN_PIN_NUM = 44;
  localparam int INOUT_PIN_NUM = 32;
  localparam int PIN_FILTER_CYCLES = 16;

  // In-pin vector sits below the inout-pin vector.
  typedef logic [IN_PIN_NUM+INOUT_PIN_NUM-1:0]
    sonata_all_in_pins_t;

  // Counter must hold 0..cycles-1; keep at least one bit.
  function automatic int filter_cnt_width(int cycles);
    int w;
    w = $clog2(cycles);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/pin_input_filter_cell.sv
// pin_filter_cell: one pin bit -- 2-flop synchroniser, glitch counter,
// registered rise/fall pulses.
// Ports: clk_i, rst_i (async high), pin_i (async pad), filter_en_i,
//        pin_o (filtered level), rise_o / fall_o (one-cycle pulses).
// Macro PIN_INPUT_FILTER_EN enables the counter; otherwise a level
// change is accepted on the first cycle it reaches sync2.
module pin_filter_cell
  import sonata_pkg::*;
#(
  parameter int   FilterCycles = PIN_FILTER_CYCLES,
  parameter logic ResetValue   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  input  logic filter_en_i,
  output logic pin_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1;
  logic sync2;
  logic upd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1 <= ResetValue;
      sync2 <= ResetValue;
    end else begin
      sync1 <= pin_i;
      sync2 <= sync1;
    end
  end

`ifdef PIN_INPUT_FILTER_EN
  localparam int CW = filter_cnt_width(FilterCycles);
  localparam logic [CW-1:0] CntMax = CW'(FilterCycles - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Counter clears whenever the level matches or is accepted, so it
  // saturates at CntMax and never wraps.
  always_comb begin
    cnt_d = '0;
    upd   = 1'b0;
    if (sync2 != pin_o) begin
      if (!filter_en_i || (cnt_q == CntMax)) begin
        upd = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unused_cycles = FilterCycles;
  logic unused_en;

  assign unused_en = filter_en_i;
  assign upd = (sync2 != pin_o);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pin_o  <= ResetValue;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      if (upd) begin
        pin_o <= sync2;
      end
      rise_o <= upd & sync2;
      fall_o <= upd & ~sync2;
    end
  end

endmodule

// File: rtl/pin_input_filter.sv
// pin_input_filter: per-bit synchronise, glitch-filter and edge-detect
// of raw pad inputs before the pinmux. Macro: PIN_INPUT_FILTER_EN.
// Ports: clk_i, rst_i (async high), pins_i, filter_en_i,
//        pins_o, rise_o, fall_o (all Width bits).
module pin_input_filter
  import sonata_pkg::*;
#(
  parameter int               Width        = IN_PIN_NUM + INOUT_PIN_NUM,
  parameter int               FilterCycles = PIN_FILTER_CYCLES,
  parameter logic [Width-1:0] ResetValue   = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] pins_i,
  input  logic [Width-1:0] filter_en_i,
  output logic [Width-1:0] pins_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o
);

  for (genvar i = 0; i < Width; i++) begin : g_cell
    pin_filter_cell #(
      .FilterCycles(FilterCycles),
      .ResetValue  (ResetValue[i])
    ) u_cell (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pin_i      (pins_i[i]),
      .filter_en_i(filter_en_i[i]),
      .pin_o      (pins_o[i]),
      .rise_o     (rise_o[i]),
      .fall_o     (fall_o[i])
    );
  end

endmodule

// File: tb/tb_pin_input_filter.sv
// Bench for pin_input_filter: two instances (reset value 0 and all-ones)
// checked every cycle against a sample-history model plus literals.
module tb_pin_input_filter;

  localparam int W  = 16;
  localparam int N  = 4;
  localparam int ME = 4096;
`ifdef PIN_INPUT_FILTER_EN
  localparam int K = N + 2;
`else
  localparam int K = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W-1:0] pins = '1;
  logic [W-1:0] en = '1;
  logic [W-1:0] po0, ri0, fa0;
  logic [W-1:0] po1, ri1, fa1;

  int total = 0;
  int bad = 0;
  logic run_chk = 1'b0;

  pin_input_filter #(
    .Width(W), .FilterCycles(N), .ResetValue('0)
  ) dut0 (
    .clk_i(clk), .rst_i(rst), .pins_i(pins), .filter_en_i(en),
    .pins_o(po0), .rise_o(ri0), .fall_o(fa0)
  );

  pin_input_filter #(
    .Width(W), .FilterCycles(N), .ResetValue('1)
  ) dut1 (
    .clk_i(clk), .rst_i(rst), .pins_i(pins), .filter_en_i(en),
    .pins_o(po1), .rise_o(ri1), .fall_o(fa1)
  );

  always #5 clk = ~clk;

  // Model: an output flips at edge e when the last n values seen by the
  // filter (pad sampled two edges earlier) all differ from it, and all n
  // edges came after the previous flip / reset.
  logic [W-1:0] raw_h[ME];
  logic [W-1:0] rv[2];
  logic [W-1:0] m_out[2];
  logic [W-1:0] m_rise[2];
  logic [W-1:0] m_fall[2];
  int chg[2][W];
  int ed = 0;
  int rst_ed = 0;

  function automatic int eff_n(logic e);
`ifdef PIN_INPUT_FILTER_EN
    return e ? N : 1;
`else
    return e ? 1 : 1;
`endif
  endfunction

  task automatic m_reset();
    rv[0] = '0;
    rv[1] = '1;
    for (int d = 0; d < 2; d++) begin
      m_out[d] = rv[d];
      m_rise[d] = '0;
      m_fall[d] = '0;
      for (int b = 0; b < W; b++) chg[d][b] = ed;
    end
  endtask

  task automatic m_step();
    int n;
    int e;
    logic u;
    logic upd;
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < W; b++) begin
        n = eff_n(en[b]);
        upd = (ed - n + 1) > chg[d][b];
        for (int j = 0; j < n; j++) begin
          e = ed - j;
          if (e - 2 > rst_ed) u = raw_h[(e-2)%ME][b];
          else u = rv[d][b];
          if (u == m_out[d][b]) upd = 1'b0;
        end
        m_rise[d][b] = upd && !m_out[d][b];
        m_fall[d][b] = upd && m_out[d][b];
        if (upd) begin
          m_out[d][b] = ~m_out[d][b];
          chg[d][b] = ed;
        end
      end
    end
  endtask

  always @(posedge rst) begin
    rst_ed = ed;
    m_reset();
  end

  always @(posedge clk) begin
    ed++;
    raw_h[ed%ME] = pins;
    if (rst) begin
      rst_ed = ed;
      m_reset();
    end else begin
      m_step();
    end
  end

  task automatic chk(string nm, logic [W-1:0] got,
                     logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run_chk) begin
      chk("pins_o0", po0, m_out[0]);
      chk("rise_o0", ri0, m_rise[0]);
      chk("fall_o0", fa0, m_fall[0]);
      chk("pins_o1", po1, m_out[1]);
      chk("rise_o1", ri1, m_rise[1]);
      chk("fall_o1", fa1, m_fall[1]);
      chk("excl0", ri0 & fa0, '0);
      chk("excl1", ri1 & fa1, '0);
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] e;
    int           h;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'hA5A5, 16'hFFFF, 8};
    tbl[1] = '{16'h5A5A, 16'h00FF, 2};
    tbl[2] = '{16'hFFFF, 16'hFF00, 6};
    tbl[3] = '{16'h0000, 16'hF0F0, 3};
    tbl[4] = '{16'h1234, 16'hFFFF, 10};
    tbl[5] = '{16'h0000, 16'h0000, 4};

    // Reset with pads high
    tick(3);
    chk("rst_pins0", po0, '0);
    chk("rst_rise0", ri0, '0);
    chk("rst_fall0", fa0, '0);
    chk("rst_pins1", po1, '1);
    run_chk = 1'b1;
    rst = 1'b0;
    tick(K - 1);
    chk("rel_pre", po0, '0);
    tick(1);
    chk("rel_pins", po0, '1);
    chk("rel_rise", ri0, '1);
    chk("rel_model", m_out[0], '1);
    chk("rel_rise1", ri1, '0);
    tick(1);
    chk("rel_rise_end", ri0, '0);

    // Filter off, bit 0
    pins = '0;
    tick(12);
    en = '0;
    pins[0] = 1'b1;
    tick(2);
    chk("off_pre", W'(po0[0]), '0);
    tick(1);
    chk("off_pins", W'(po0[0]), W'(1));
    chk("off_rise", ri0, W'(1));
    tick(1);
    chk("off_rise_end", W'(ri0[0]), '0);

    // Filter on, bit 5 short pulse then held
    en = '1;
    pins[5] = 1'b1;
    tick(3);
    pins[5] = 1'b0;
    tick(10);
    chk("glitch_pins", W'(po0[5]), '0);
    pins[5] = 1'b1;
    tick(N + 1);
`ifdef PIN_INPUT_FILTER_EN
    chk("held_pre", W'(po0[5]), '0);
    chk("held_model", W'(m_out[0][5]), '0);
`endif
    tick(1);
    chk("held_pins", W'(po0[5]), W'(1));

    // Reset mid-count on bit 7, then release
    pins[7] = 1'b1;
    tick(3);
    rst = 1'b1;
    pins[7] = 1'b0;
    tick(1);
    chk("mid_rst", po0, '0);
    rst = 1'b0;
    tick(K);
    chk("rel2_pins0", po0, 16'h0021);
    chk("rel2_rise0", ri0, 16'h0021);
    chk("rel2_pins1", po1, 16'h0021);
    chk("rel2_fall1", fa1, 16'hFFDE);
    chk("rel2_rise1", ri1, '0);
    tick(4);

    // Drop filter enable on bit 9 after two counts
    pins[9] = 1'b1;
    tick(4);
`ifdef PIN_INPUT_FILTER_EN
    chk("en_drop_pre", W'(po0[9]), '0);
`endif
    en[9] = 1'b0;
    tick(1);
    chk("en_drop_pins", W'(po0[9]), W'(1));
    tick(3);
    en = '1;

    // Multi-bit patterns with mixed enables
    foreach (tbl[i]) begin
      pins = tbl[i].p;
      en = tbl[i].e;
      tick(tbl[i].h);
    end
    pins = 16'hC3C3;
    en = '1;
    tick(12);
    chk("final_pins0", po0, 16'hC3C3);
    chk("final_pins1", po1, 16'hC3C3);

    run_chk = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
